// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
//  Module   : alu_cmd_sequencer
//  Purpose  : Command-queue controller for the 4-bit ALU behind the Tiny
//             Tapeout pin interface. The host pushes commands over a
//             level-sensitive valid/ready handshake into a small FIFO. The
//             commands run one at a time: logic and add operations take one
//             cycle, and multiply/divide take four cycles each. Every 8-bit
//             result stays on uo_out until the host acknowledges it.
//  Ports    : clk      - rising-edge clock
//             rst_n    - asynchronous active-low reset
//             ui_in    - [7:4] operand A, [3:0] operand B
//             uio_in   - [2:0] opcode, [3] cmd_valid, [4] use_acc,
//                        [5] result_ack, [7:6] ignored
//             uo_out   - result register
//             uio_out  - [7] result_valid, [6] cmd_ready, [5] overflow
//                        (sticky), [4:0] zero
//             uio_oe   - constant 8'hE0
//  Options  : define ALU_CMD_SEQ_DIV_EN to build the restoring divider. When
//             it is not defined, opcode 111 finishes in one cycle with 8'h00.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_depth_cnt = DEPTH;
    localparam logic [c_cnt_w-1:0] c_cnt_one   = 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one   = 1;

    localparam logic [2:0] c_op_add = 3'b000;
    localparam logic [2:0] c_op_sub = 3'b001;
    localparam logic [2:0] c_op_and = 3'b010;
    localparam logic [2:0] c_op_or  = 3'b011;
    localparam logic [2:0] c_op_xor = 3'b100;
    localparam logic [2:0] c_op_not = 3'b101;
    localparam logic [2:0] c_op_mul = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Pin decode
    // ------------------------------------------------------------------
    logic [2:0] w_opcode;
    logic       w_cmd_valid;
    logic       w_use_acc;
    logic       w_ack;

    assign w_opcode    = uio_in[2:0];
    assign w_cmd_valid = uio_in[3];
    assign w_use_acc   = uio_in[4];
    assign w_ack       = uio_in[5];

    // ------------------------------------------------------------------
    // Command FIFO: entry = {opcode, use_acc, A, B}
    // ------------------------------------------------------------------
    logic [11:0]        r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_overflow;

    state_t      r_state;
    logic        w_cmd_ready;
    logic        w_push;
    logic        w_pop;
    logic [11:0] w_head;
    logic [3:0]  w_pop_a;
    logic [7:0]  r_acc;

    assign w_cmd_ready = (r_count < c_depth_cnt);
    assign w_push      = w_cmd_valid & w_cmd_ready;
    assign w_pop       = (r_state == ST_IDLE) && (r_count != '0);
    assign w_head      = r_mem[r_rd_ptr];
    // Chained commands take A from the accumulator as it is at pop time.
    // That is why they can sit in the queue behind the command they depend on.
    assign w_pop_a     = w_head[8] ? r_acc[3:0] : w_head[7:4];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_opcode, w_use_acc, ui_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
            if (w_cmd_valid && !w_cmd_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Execution datapath
    // ------------------------------------------------------------------
    logic [2:0] r_op;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [7:0] r_mcand;
    logic [3:0] r_mplier;
    logic [7:0] r_prod;
    logic [1:0] r_iter;
    logic [7:0] r_result;
    logic       r_result_valid;

    logic [7:0] w_simple;
    logic [7:0] w_prod_next;
    logic [7:0] w_iter_result;
    logic       w_is_iter;
    logic       w_unused_bits;

    always_comb begin
        w_simple = 8'h00;
        case (r_op)
            c_op_add: w_simple = {3'b000, {1'b0, r_a} + {1'b0, r_b}};
            c_op_sub: w_simple = {4'h0, r_a} - {4'h0, r_b};
            c_op_and: w_simple = {4'h0, r_a & r_b};
            c_op_or:  w_simple = {4'h0, r_a | r_b};
            c_op_xor: w_simple = {4'h0, r_a ^ r_b};
            c_op_not: w_simple = {4'h0, ~r_a};
            default:  w_simple = 8'h00;
        endcase
    end

    // One shift-add step. The multiplicand shifts left and the multiplier
    // shifts right, so only the multiplier LSB is checked at each step.
    assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : 8'h00);

`ifdef ALU_CMD_SEQ_DIV_EN
    // Restoring divide. r_quo starts as the dividend and shifts left one bit
    // per step. Each step moves one dividend bit into the partial remainder
    // and shifts one quotient bit in at the bottom.
    logic [3:0] r_rem;
    logic [3:0] r_quo;
    logic [4:0] w_trial;
    logic [4:0] w_diff;
    logic       w_fits;
    logic [3:0] w_rem_next;
    logic [3:0] w_quo_next;
    logic [7:0] w_div_result;

    assign w_trial       = {r_rem, r_quo[3]};
    assign w_diff        = w_trial - {1'b0, r_b};
    assign w_fits        = (w_trial >= {1'b0, r_b});
    assign w_rem_next    = w_fits ? w_diff[3:0] : w_trial[3:0];
    assign w_quo_next    = {r_quo[2:0], w_fits};
    assign w_div_result  = (r_b == 4'h0) ? 8'hFF : {w_rem_next, w_quo_next};
    assign w_is_iter     = (r_op[2:1] == 2'b11);
    assign w_iter_result = r_op[0] ? w_div_result : w_prod_next;
    assign w_unused_bits = ^{uio_in[7:6], r_acc[7:4], w_diff[4]};
`else
    assign w_is_iter     = (r_op == c_op_mul);
    assign w_iter_result = w_prod_next;
    assign w_unused_bits = ^{uio_in[7:6], r_acc[7:4]};
`endif

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_op           <= 3'b000;
            r_a            <= 4'h0;
            r_b            <= 4'h0;
            r_mcand        <= 8'h00;
            r_mplier       <= 4'h0;
            r_prod         <= 8'h00;
            r_iter         <= 2'd0;
            r_result       <= 8'h00;
            r_result_valid <= 1'b0;
            r_acc          <= 8'h00;
`ifdef ALU_CMD_SEQ_DIV_EN
            r_rem          <= 4'h0;
            r_quo          <= 4'h0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_op     <= w_head[11:9];
                        r_a      <= w_pop_a;
                        r_b      <= w_head[3:0];
                        r_mcand  <= {4'h0, w_pop_a};
                        r_mplier <= w_head[3:0];
                        r_prod   <= 8'h00;
                        r_iter   <= 2'd0;
`ifdef ALU_CMD_SEQ_DIV_EN
                        r_rem    <= 4'h0;
                        r_quo    <= w_pop_a;
`endif
                        r_state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (!w_is_iter) begin
                        r_result       <= w_simple;
                        r_acc          <= w_simple;
                        r_result_valid <= 1'b1;
                        r_state        <= ST_DONE;
                    end else begin
                        r_iter   <= r_iter + 2'd1;
                        r_prod   <= w_prod_next;
                        r_mcand  <= {r_mcand[6:0], 1'b0};
                        r_mplier <= {1'b0, r_mplier[3:1]};
`ifdef ALU_CMD_SEQ_DIV_EN
                        r_rem    <= w_rem_next;
                        r_quo    <= w_quo_next;
`endif
                        if (r_iter == 2'd3) begin
                            r_result       <= w_iter_result;
                            r_acc          <= w_iter_result;
                            r_result_valid <= 1'b1;
                            r_state        <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (w_ack) begin
                        r_result_valid <= 1'b0;
                        r_state        <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign uo_out  = r_result;
    assign uio_out = {r_result_valid, w_cmd_ready, r_overflow, 5'b00000};
    assign uio_oe  = 8'hE0;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// ============================================================================
//  Module   : tb_alu_cmd_sequencer
//  Purpose  : Directed self-checking bench for alu_cmd_sequencer. Each
//             vector comes with a hand-computed result and a latency check.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_cmd_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    int n_cmp;
    int n_err;

`ifdef ALU_CMD_SEQ_DIV_EN
    localparam logic [7:0] c_div_2_8 = 8'h20;
    localparam logic [7:0] c_div_9_0 = 8'hFF;
    localparam int         c_div_lat = 5;
`else
    localparam logic [7:0] c_div_2_8 = 8'h00;
    localparam logic [7:0] c_div_9_0 = 8'h00;
    localparam int         c_div_lat = 2;
`endif

    alu_cmd_sequencer #(.DEPTH(4)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    task automatic chk_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic [3:0] a,
                            input logic [3:0] b, input logic ua);
        ui_in  = {a, b};
        uio_in = {2'b00, 1'b0, ua, 1'b1, op};
        tick();
        uio_in = 8'h00;
    endtask

    task automatic do_ack();
        uio_in[5] = 1'b1;
        tick();
        uio_in[5] = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int i;
        i = 0;
        while (!uio_out[7] && i < budget) begin
            tick();
            i++;
        end
        chk_val({tag, " result_valid"}, {7'b0, uio_out[7]}, 8'h01);
    endtask

    // Push one command into an idle, empty sequencer. Check that
    // result_valid is still low one cycle early, then check the result at
    // the expected edge, that it holds, and that the ack clears it.
    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [3:0] a,
                           input logic [3:0] b, input logic ua,
                           input logic [7:0] exp, input int lat);
        push_cmd(op, a, b, ua);
        repeat (lat - 1) tick();
        chk_val({tag, " early"}, {7'b0, uio_out[7]}, 8'h00);
        tick();
        chk_val({tag, " valid"}, {7'b0, uio_out[7]}, 8'h01);
        chk_val({tag, " data"}, uo_out, exp);
        tick();
        chk_val({tag, " hold"}, {uio_out[7], uo_out[6:0]}, {1'b1, exp[6:0]});
        do_ack();
        chk_val({tag, " ack clears"}, {7'b0, uio_out[7]}, 8'h00);
    endtask

    initial begin
        logic saw_valid;
        n_cmp  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        // Reset
        repeat (3) tick();
        chk_val("rst uo_out", uo_out, 8'h00);
        chk_val("rst uio_out", uio_out, 8'h40);
        chk_val("rst uio_oe", uio_oe, 8'hE0);
        rst_n = 1'b1;
        tick();
        chk_val("post-rst uio_out", uio_out, 8'h40);

        // Single-cycle operations
        run_cmd("add 1+2", 3'b000, 4'd1, 4'd2, 1'b0, 8'h03, 2);
        run_cmd("sub 4-3", 3'b001, 4'd4, 4'd3, 1'b0, 8'h01, 2);
        run_cmd("sub 3-4", 3'b001, 4'd3, 4'd4, 1'b0, 8'hFF, 2);
        run_cmd("and",     3'b010, 4'hC, 4'hA, 1'b0, 8'h08, 2);
        run_cmd("or",      3'b011, 4'hC, 4'hA, 1'b0, 8'h0E, 2);
        run_cmd("xor",     3'b100, 4'hC, 4'hA, 1'b0, 8'h06, 2);
        run_cmd("not 5",   3'b101, 4'h5, 4'h0, 1'b0, 8'h0A, 2);
        run_cmd("add F+F", 3'b000, 4'hF, 4'hF, 1'b0, 8'h1E, 2);

        // Multiply / divide
        run_cmd("mul 3*2", 3'b110, 4'd3, 4'd2, 1'b0, 8'h06, 5);
        run_cmd("div 2/8", 3'b111, 4'd2, 4'd8, 1'b0, c_div_2_8, c_div_lat);
        run_cmd("div 9/0", 3'b111, 4'd9, 4'd0, 1'b0, c_div_9_0, c_div_lat);
        run_cmd("mul F*F", 3'b110, 4'hF, 4'hF, 1'b0, 8'hE1, 5);

        // Accumulator chaining: the A field of a use_acc command is ignored
        run_cmd("chain add", 3'b000, 4'd1, 4'd2, 1'b0, 8'h03, 2);
        run_cmd("chain acc+4", 3'b000, 4'd9, 4'd4, 1'b1, 8'h07, 2);
        run_cmd("chain not acc", 3'b101, 4'd0, 4'd0, 1'b1, 8'h08, 2);

        // Chained command queued back to back with its producer
        push_cmd(3'b000, 4'd1, 4'd2, 1'b0);
        push_cmd(3'b000, 4'd0, 4'd4, 1'b1);
        wait_valid("queued 1st", 8);
        chk_val("queued 1st data", uo_out, 8'h03);
        do_ack();
        wait_valid("queued 2nd", 8);
        chk_val("queued 2nd data", uo_out, 8'h07);
        do_ack();

        // Fill to overflow with ack held low
        for (int k = 0; k < 6; k++) begin
            ui_in  = {k[3:0], 4'h1};
            uio_in = 8'h08;
            tick();
            if (k == 3) chk_val("ready after 4 pushes", {7'b0, uio_out[6]}, 8'h01);
            if (k == 4) chk_val("ready after 5 pushes", {7'b0, uio_out[6]}, 8'h00);
            if (k == 4) chk_val("ovf after 5 pushes", {7'b0, uio_out[5]}, 8'h00);
            if (k == 5) chk_val("ovf after 6 pushes", {7'b0, uio_out[5]}, 8'h01);
        end
        uio_in = 8'h00;
        for (int k = 0; k < 5; k++) begin
            logic [7:0] exp_res;
            exp_res = 8'(k + 1);
            wait_valid($sformatf("drain %0d", k), 8);
            chk_val($sformatf("drain %0d data", k), uo_out, exp_res);
            do_ack();
        end
        repeat (6) tick();
        chk_val("no 6th result", {7'b0, uio_out[7]}, 8'h00);
        chk_val("ready after drain", {7'b0, uio_out[6]}, 8'h01);
        chk_val("ovf sticky", {7'b0, uio_out[5]}, 8'h01);

        // Reset in the middle of a multiply
        push_cmd(3'b110, 4'hF, 4'hF, 1'b0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_val("mid-mul rst uo_out", uo_out, 8'h00);
        chk_val("mid-mul rst uio_out", uio_out, 8'h40);
        chk_val("mid-mul rst uio_oe", uio_oe, 8'hE0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (uio_out[7]) saw_valid = 1'b1;
        end
        chk_val("no result after rst", {7'b0, saw_valid}, 8'h00);
        run_cmd("mul after rst", 3'b110, 4'd5, 4'd7, 1'b0, 8'h23, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
